// File: rtl/ht_table_pkg.sv
// Shared types and sizing for the chained-bucket hash table subsystem.
package hash_table;

    localparam int KEY_WIDTH        = 32;
    localparam int VALUE_WIDTH      = 16;
    localparam int BUCKET_WIDTH     = 8;
    localparam int TABLE_ADDR_WIDTH = 10;
    localparam     HASH_TYPE        = "dummy";

    typedef logic [KEY_WIDTH-1:0]        key_t;
    typedef logic [VALUE_WIDTH-1:0]      value_t;
    typedef logic [BUCKET_WIDTH-1:0]     bucket_t;
    typedef logic [TABLE_ADDR_WIDTH-1:0] tbl_addr_t;

    typedef enum logic [2:0] {
        OP_INIT   = 3'd0,
        OP_SEARCH = 3'd1,
        OP_INSERT = 3'd2,
        OP_DELETE = 3'd3
    } opcode_t;

    typedef enum logic [2:0] {
        INIT_SUCCESS,
        SEARCH_FOUND,
        SEARCH_NOT_SUCCESS_NO_ENTRY,
        INSERT_SUCCESS,
        INSERT_SUCCESS_SAME_KEY,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL,
        DELETE_SUCCESS,
        DELETE_NOT_SUCCESS_NO_ENTRY
    } rescode_t;

    typedef enum logic [1:0] {
        NO_CHAIN,
        IN_HEAD,
        IN_MIDDLE,
        IN_TAIL
    } chain_state_t;

    typedef enum logic [2:0] {
        ST_INIT_SWEEP,
        ST_IDLE,
        ST_RD_HEAD,
        ST_RD_DATA,
        ST_CMP,
        ST_WR,
        ST_RESULT
    } state_t;

    typedef struct packed {
        opcode_t opcode;
        key_t    key;
        value_t  value;
    } ht_command_t;

    typedef struct packed {
        ht_command_t  cmd;
        rescode_t     rescode;
        bucket_t      bucket;
        value_t       found_value;
        chain_state_t chain_state;
    } ht_result_t;

    typedef struct packed {
        tbl_addr_t ptr;
        logic      ptr_val;
    } head_ram_data_t;

    typedef struct packed {
        key_t      key;
        value_t    value;
        tbl_addr_t next_ptr;
        logic      next_ptr_val;
    } ram_data_t;

    function automatic bucket_t calc_hash(input key_t key);
        return key[KEY_WIDTH-1 -: BUCKET_WIDTH];
    endfunction

endpackage

// File: rtl/ht_cmd_if.sv
// Command channel into the hash table (valid/ready).
interface ht_cmd_if;
    import hash_table::*;

    logic        valid;
    logic        ready;
    ht_command_t cmd;

    modport slave  (input valid, input cmd, output ready);
    modport master (output valid, output cmd, input ready);
endinterface

// File: rtl/ht_res_if.sv
// Result channel out of the hash table (valid/ready).
interface ht_res_if;
    import hash_table::*;

    logic       valid;
    logic       ready;
    ht_result_t result;

    modport master (output valid, output result, input ready);
    modport slave  (input valid, input result, output ready);
endinterface

// File: rtl/ht_table_empty_ptr_storage.sv
// Free data-table address store: never-used addresses come from a counter,
// released addresses are recycled through a LIFO.
module ht_empty_ptr_storage
    import hash_table::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      srst_i,
    input  tbl_addr_t add_empty_ptr_i,
    input  logic      add_empty_ptr_en_i,
    input  logic      empty_addr_rd_ack_i,
    output tbl_addr_t empty_addr_o,
    output logic      empty_addr_val_o
);

    localparam int AW    = TABLE_ADDR_WIDTH;
    localparam int DEPTH = 2**AW;

    logic [AW:0] fresh_q;
    logic [AW:0] sp_q;
    tbl_addr_t   stack_q [DEPTH];
    tbl_addr_t   top_idx;
    logic        recycled;

    assign recycled         = (sp_q != '0);
    assign top_idx          = sp_q[AW-1:0] - AW'(1);
    assign empty_addr_o     = recycled ? stack_q[top_idx] : fresh_q[AW-1:0];
    assign empty_addr_val_o = recycled || !fresh_q[AW];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i || srst_i) begin
            fresh_q <= '0;
            sp_q    <= '0;
        end else if (add_empty_ptr_en_i) begin
            sp_q <= sp_q + (AW+1)'(1);
        end else if (empty_addr_rd_ack_i) begin
            if (recycled) sp_q    <= sp_q - (AW+1)'(1);
            else          fresh_q <= fresh_q + (AW+1)'(1);
        end
    end

    // NOTE: storage arrays are not reset; the stack pointer alone defines which slots are live.
    always_ff @(posedge clk_i) begin
        if (add_empty_ptr_en_i) stack_q[sp_q[AW-1:0]] <= add_empty_ptr_i;
    end

endmodule

// File: rtl/ht_table_top.sv
// Chained-bucket hash table: head-pointer RAM, data RAM, free-address store,
// and a command FSM that walks one chain per command.
module ht_table_top
    import hash_table::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    ht_cmd_if.slave  ht_cmd_in,
    ht_res_if.master ht_res_out
);

    localparam int HEAD_DEPTH = 2**BUCKET_WIDTH;
    localparam int DATA_DEPTH = 2**TABLE_ADDR_WIDTH;

    state_t         state_q;
    bucket_t        sweep_cnt_q;
    logic           init_cmd_q;
    ht_command_t    cmd_q;
    bucket_t        bucket_q;
    head_ram_data_t head_q;
    tbl_addr_t      cur_ptr_q, prev_ptr_q;
    key_t           prev_key_q;
    value_t         prev_value_q;
    logic           is_head_q, chain_empty_q;
    ht_result_t     res_q;

    logic           head_wr_en_q, data_wr_en_q;
    bucket_t        head_wr_addr_q;
    head_ram_data_t head_wr_data_q;
    tbl_addr_t      data_wr_addr_q;
    ram_data_t      data_wr_data_q;

    // Monitoring nets
    logic           head_table_wr_en;
    bucket_t        head_table_wr_addr, head_table_rd_addr;
    head_ram_data_t head_table_wr_data, head_table_rd_data;
    logic           data_table_wr_en;
    tbl_addr_t      data_table_wr_addr, data_table_rd_addr;
    ram_data_t      data_table_wr_data, data_table_rd_data;
    tbl_addr_t      add_empty_ptr, empty_addr;
    logic           add_empty_ptr_en, empty_addr_val, empty_addr_rd_ack;
    logic           empty_ptr_storage_srst_w;

    head_ram_data_t head_mem [HEAD_DEPTH];
    ram_data_t      data_mem [DATA_DEPTH];

    // The sweep owns the head write port directly so it clears one bucket per cycle.
    assign empty_ptr_storage_srst_w = (state_q == ST_INIT_SWEEP);
    assign head_table_wr_en   = empty_ptr_storage_srst_w | head_wr_en_q;
    assign head_table_wr_addr = empty_ptr_storage_srst_w ? sweep_cnt_q : head_wr_addr_q;
    assign head_table_wr_data = empty_ptr_storage_srst_w ? '0 : head_wr_data_q;
    assign head_table_rd_addr = (state_q == ST_IDLE) ? calc_hash(ht_cmd_in.cmd.key) : bucket_q;
    assign data_table_wr_en   = data_wr_en_q;
    assign data_table_wr_addr = data_wr_addr_q;
    assign data_table_wr_data = data_wr_data_q;
    assign data_table_rd_addr = cur_ptr_q;

    always_ff @(posedge clk_i) begin
        if (head_table_wr_en) head_mem[head_table_wr_addr] <= head_table_wr_data;
        head_table_rd_data <= head_mem[head_table_rd_addr];
    end

    always_ff @(posedge clk_i) begin
        if (data_table_wr_en) data_mem[data_table_wr_addr] <= data_table_wr_data;
        data_table_rd_data <= data_mem[data_table_rd_addr];
    end

    ht_empty_ptr_storage u_empty_ptr_storage (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .srst_i              (empty_ptr_storage_srst_w),
        .add_empty_ptr_i     (add_empty_ptr),
        .add_empty_ptr_en_i  (add_empty_ptr_en),
        .empty_addr_rd_ack_i (empty_addr_rd_ack),
        .empty_addr_o        (empty_addr),
        .empty_addr_val_o    (empty_addr_val)
    );

    ram_data_t    entry;
    logic         hit_w, more_w;
    chain_state_t chain_w;

    assign entry   = data_table_rd_data;
    assign hit_w   = !chain_empty_q && (entry.key == cmd_q.key);
    assign more_w  = !chain_empty_q && !hit_w && entry.next_ptr_val;
    assign chain_w = chain_empty_q      ? NO_CHAIN :
                     is_head_q          ? IN_HEAD  :
                     !entry.next_ptr_val ? IN_TAIL : IN_MIDDLE;

    assign ht_cmd_in.ready   = (state_q == ST_IDLE);
    assign ht_res_out.valid  = (state_q == ST_RESULT);
    assign ht_res_out.result = res_q;

    function automatic ht_result_t mk_res(input ht_command_t c, input rescode_t rc,
                                          input value_t v, input chain_state_t cs);
        ht_result_t r;
        r.cmd         = c;
        r.rescode     = rc;
        r.bucket      = calc_hash(c.key);
        r.found_value = v;
        r.chain_state = cs;
        return r;
    endfunction

    logic      rd_ack_q, add_en_q;
    tbl_addr_t add_ptr_q;

    assign add_empty_ptr     = add_ptr_q;
    assign add_empty_ptr_en  = add_en_q;
    assign empty_addr_rd_ack = rd_ack_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q        <= ST_INIT_SWEEP;
            sweep_cnt_q    <= '0;
            init_cmd_q     <= 1'b0;
            cmd_q          <= '0;
            bucket_q       <= '0;
            head_q         <= '0;
            cur_ptr_q      <= '0;
            prev_ptr_q     <= '0;
            prev_key_q     <= '0;
            prev_value_q   <= '0;
            is_head_q      <= 1'b0;
            chain_empty_q  <= 1'b0;
            res_q          <= '0;
            head_wr_en_q   <= 1'b0;
            head_wr_addr_q <= '0;
            head_wr_data_q <= '0;
            data_wr_en_q   <= 1'b0;
            data_wr_addr_q <= '0;
            data_wr_data_q <= '0;
            rd_ack_q       <= 1'b0;
            add_en_q       <= 1'b0;
            add_ptr_q      <= '0;
        end else begin
            head_wr_en_q <= 1'b0;
            data_wr_en_q <= 1'b0;
            rd_ack_q     <= 1'b0;
            add_en_q     <= 1'b0;
            case (state_q)
                ST_INIT_SWEEP: begin
                    sweep_cnt_q <= sweep_cnt_q + BUCKET_WIDTH'(1);
                    if (sweep_cnt_q == '1) begin
                        init_cmd_q <= 1'b0;
                        if (init_cmd_q) begin
                            res_q   <= mk_res(cmd_q, INIT_SUCCESS, '0, NO_CHAIN);
                            state_q <= ST_RESULT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: if (ht_cmd_in.valid) begin
                    cmd_q    <= ht_cmd_in.cmd;
                    bucket_q <= calc_hash(ht_cmd_in.cmd.key);
                    case (ht_cmd_in.cmd.opcode)
                        OP_INIT: begin
                            init_cmd_q  <= 1'b1;
                            sweep_cnt_q <= '0;
                            state_q     <= ST_INIT_SWEEP;
                        end
                        OP_SEARCH, OP_INSERT, OP_DELETE: state_q <= ST_RD_HEAD;
                        default: begin
                            res_q   <= mk_res(ht_cmd_in.cmd, DELETE_NOT_SUCCESS_NO_ENTRY, '0, NO_CHAIN);
                            state_q <= ST_RESULT;
                        end
                    endcase
                end
                ST_RD_HEAD: begin
                    head_q        <= head_table_rd_data;
                    is_head_q     <= 1'b1;
                    chain_empty_q <= !head_table_rd_data.ptr_val;
                    cur_ptr_q     <= head_table_rd_data.ptr;
                    state_q       <= head_table_rd_data.ptr_val ? ST_RD_DATA : ST_CMP;
                end
                ST_RD_DATA: state_q <= ST_CMP;
                ST_CMP: begin
                    if (more_w) begin
                        prev_ptr_q   <= cur_ptr_q;
                        prev_key_q   <= entry.key;
                        prev_value_q <= entry.value;
                        is_head_q    <= 1'b0;
                        cur_ptr_q    <= entry.next_ptr;
                        state_q      <= ST_RD_DATA;
                    end else begin
                        state_q <= ST_RESULT;
                        case (cmd_q.opcode)
                            OP_SEARCH: res_q <= hit_w ?
                                mk_res(cmd_q, SEARCH_FOUND, entry.value, chain_w) :
                                mk_res(cmd_q, SEARCH_NOT_SUCCESS_NO_ENTRY, '0, chain_w);
                            OP_INSERT: begin
                                if (hit_w) begin
                                    data_wr_en_q   <= 1'b1;
                                    data_wr_addr_q <= cur_ptr_q;
                                    data_wr_data_q <= '{entry.key, cmd_q.value, entry.next_ptr, entry.next_ptr_val};
                                    res_q          <= mk_res(cmd_q, INSERT_SUCCESS_SAME_KEY, '0, chain_w);
                                    state_q        <= ST_WR;
                                end else if (!empty_addr_val) begin
                                    res_q <= mk_res(cmd_q, INSERT_NOT_SUCCESS_TABLE_IS_FULL, '0, chain_w);
                                end else begin
                                    data_wr_en_q   <= 1'b1;
                                    data_wr_addr_q <= empty_addr;
                                    data_wr_data_q <= '{cmd_q.key, cmd_q.value, head_q.ptr, head_q.ptr_val};
                                    head_wr_en_q   <= 1'b1;
                                    head_wr_addr_q <= bucket_q;
                                    head_wr_data_q <= '{empty_addr, 1'b1};
                                    rd_ack_q       <= 1'b1;
                                    res_q          <= mk_res(cmd_q, INSERT_SUCCESS, '0, chain_w);
                                    state_q        <= ST_WR;
                                end
                            end
                            OP_DELETE: begin
                                if (hit_w) begin
                                    if (is_head_q) begin
                                        head_wr_en_q   <= 1'b1;
                                        head_wr_addr_q <= bucket_q;
                                        head_wr_data_q <= '{entry.next_ptr, entry.next_ptr_val};
                                    end else begin
                                        data_wr_en_q   <= 1'b1;
                                        data_wr_addr_q <= prev_ptr_q;
                                        data_wr_data_q <= '{prev_key_q, prev_value_q, entry.next_ptr, entry.next_ptr_val};
                                    end
                                    add_en_q  <= 1'b1;
                                    add_ptr_q <= cur_ptr_q;
                                    res_q     <= mk_res(cmd_q, DELETE_SUCCESS, '0, chain_w);
                                    state_q   <= ST_WR;
                                end else begin
                                    res_q <= mk_res(cmd_q, DELETE_NOT_SUCCESS_NO_ENTRY, '0, chain_w);
                                end
                            end
                            default: res_q <= mk_res(cmd_q, DELETE_NOT_SUCCESS_NO_ENTRY, '0, NO_CHAIN);
                        endcase
                    end
                end
                ST_WR:     state_q <= ST_RESULT;
                ST_RESULT: if (ht_res_out.ready) state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ht_table_top.sv
// Directed bench for ht_table_top: chain handling, capacity, backpressure, reset.
module tb_ht_table_top;
    import hash_table::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ht_cmd_if cmd_if ();
    ht_res_if res_if ();

    ht_table_top dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .ht_cmd_in  (cmd_if),
        .ht_res_out (res_if)
    );

    int total = 0;
    int bad   = 0;
    tbl_addr_t last_data_wr_addr = '0;
    ht_result_t r;

    always @(negedge clk) if (dut.data_table_wr_en) last_data_wr_addr = dut.data_table_wr_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input opcode_t op, input key_t key, input value_t val);
        int n;
        @(negedge clk);
        cmd_if.cmd   = '{opcode: op, key: key, value: val};
        cmd_if.valid = 1'b1;
        n = 0;
        while (cmd_if.ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++; bad++;
            $error("FAIL cmd_accept_timeout: observed ready=0 expected ready=1");
        end
        @(posedge clk);
        #1 cmd_if.valid = 1'b0;
    endtask

    task automatic wait_res(output ht_result_t res);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (res_if.valid !== 1'b1 && n < 2000);
        if (n >= 2000) begin
            total++; bad++;
            $error("FAIL res_valid_timeout: observed valid=0 expected valid=1");
        end
        res = res_if.result;
    endtask

    task automatic retire();
        res_if.ready = 1'b1;
        @(posedge clk);
        #1 res_if.ready = 1'b0;
    endtask

    task automatic send(input opcode_t op, input key_t key, input value_t val, output ht_result_t res);
        issue(op, key, val);
        wait_res(res);
        retire();
    endtask

    function automatic key_t cap_key(input int i);
        return key_t'(i) * 32'h9E3779B1;
    endfunction

    function automatic value_t cap_val(input int i);
        return value_t'(i) ^ 16'hA5A5;
    endfunction

    initial begin
        rst_n        = 1'b0;
        cmd_if.valid = 1'b0;
        cmd_if.cmd   = '0;
        res_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res_valid", res_if.valid, 1'b0);
        check("rst_cmd_ready", cmd_if.ready, 1'b0);
        check("rst_result", res_if.result, '0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("sweep_ready_low", cmd_if.ready, 1'b0);

        send(OP_INIT, '0, '0, r);
        check("init_rc", r.rescode, INIT_SUCCESS);
        send(OP_SEARCH, 32'h04000000, '0, r);
        check("empty_search_rc", r.rescode, SEARCH_NOT_SUCCESS_NO_ENTRY);
        check("empty_search_bucket", r.bucket, 8'h04);
        check("empty_search_chain", r.chain_state, NO_CHAIN);
        send(OP_DELETE, 32'h04111111, '0, r);
        check("empty_delete_rc", r.rescode, DELETE_NOT_SUCCESS_NO_ENTRY);

        // Bucket 0x01: addr0 then addr1; chain head=1 -> 0
        send(OP_INSERT, 32'h01000000, 16'h1234, r);
        check("ins_a_rc", r.rescode, INSERT_SUCCESS);
        check("ins_a_wr_addr", last_data_wr_addr, 10'd0);
        send(OP_INSERT, 32'h01001000, 16'h1235, r);
        check("ins_b_rc", r.rescode, INSERT_SUCCESS);
        check("ins_b_chain", r.chain_state, IN_HEAD);
        send(OP_INSERT, 32'h01000000, 16'hBEEF, r);
        check("ins_same_rc", r.rescode, INSERT_SUCCESS_SAME_KEY);
        check("ins_same_chain", r.chain_state, IN_TAIL);
        send(OP_SEARCH, 32'h01000000, '0, r);
        check("srch_a_rc", r.rescode, SEARCH_FOUND);
        check("srch_a_val", r.found_value, 16'hBEEF);
        send(OP_SEARCH, 32'h01001000, '0, r);
        check("srch_b_val", r.found_value, 16'h1235);
        check("srch_b_chain", r.chain_state, IN_HEAD);

        // Bucket 0x05 at addrs 2..5; chain k3 -> k2 -> k1 -> k0
        for (int i = 0; i < 4; i++) begin
            send(OP_INSERT, 32'h05000000 + key_t'(i), 16'h5000 + value_t'(i), r);
            check($sformatf("chain_ins_%0d", i), r.rescode, INSERT_SUCCESS);
        end
        send(OP_DELETE, 32'h05000001, '0, r);
        check("del_mid_rc", r.rescode, DELETE_SUCCESS);
        check("del_mid_chain", r.chain_state, IN_MIDDLE);
        send(OP_SEARCH, 32'h05000000, '0, r);
        check("after_del_k0", r.found_value, 16'h5000);
        check("after_del_k0_chain", r.chain_state, IN_TAIL);
        send(OP_SEARCH, 32'h05000002, '0, r);
        check("after_del_k2", r.found_value, 16'h5002);
        send(OP_SEARCH, 32'h05000003, '0, r);
        check("after_del_k3", r.found_value, 16'h5003);
        send(OP_SEARCH, 32'h05000001, '0, r);
        check("after_del_k1_rc", r.rescode, SEARCH_NOT_SUCCESS_NO_ENTRY);
        send(OP_INSERT, 32'h06000000, 16'h6666, r);
        check("reuse_rc", r.rescode, INSERT_SUCCESS);
        check("reuse_addr", last_data_wr_addr, 10'd3);

        // Only entry of bucket 0x06: delete must clear the head valid flag
        send(OP_DELETE, 32'h06000000, '0, r);
        check("del_last_rc", r.rescode, DELETE_SUCCESS);
        send(OP_SEARCH, 32'h06000000, '0, r);
        check("del_last_chain", r.chain_state, NO_CHAIN);

        send(OP_INSERT, 32'h04000000, 16'h4444, r);
        check("near_ins_rc", r.rescode, INSERT_SUCCESS);
        send(OP_SEARCH, 32'h04100000, '0, r);
        check("near_srch_rc", r.rescode, SEARCH_NOT_SUCCESS_NO_ENTRY);
        send(OP_SEARCH, 32'h04000000, '0, r);
        check("near_hit_val", r.found_value, 16'h4444);
        send(OP_DELETE, 32'h04100000, '0, r);
        check("near_del_rc", r.rescode, DELETE_NOT_SUCCESS_NO_ENTRY);

        send(opcode_t'(3'd5), 32'h04000000, '0, r);
        check("unknown_op_rc", r.rescode, DELETE_NOT_SUCCESS_NO_ENTRY);
        send(OP_SEARCH, 32'h04000000, '0, r);
        check("unknown_op_nowrite", r.found_value, 16'h4444);

        // Capacity
        send(OP_INIT, '0, '0, r);
        check("cap_init_rc", r.rescode, INIT_SUCCESS);
        for (int i = 0; i < 1034; i++) begin
            send(OP_INSERT, cap_key(i), cap_val(i), r);
            check($sformatf("cap_ins_%0d", i), r.rescode,
                  (i < 1024) ? INSERT_SUCCESS : INSERT_NOT_SUCCESS_TABLE_IS_FULL);
        end
        send(OP_SEARCH, cap_key(1033), '0, r);
        check("cap_full_nowrite", r.rescode, SEARCH_NOT_SUCCESS_NO_ENTRY);
        send(OP_DELETE, cap_key(5), '0, r);
        check("cap_del_rc", r.rescode, DELETE_SUCCESS);
        send(OP_INSERT, cap_key(1030), cap_val(1030), r);
        check("cap_reins_rc", r.rescode, INSERT_SUCCESS);
        send(OP_SEARCH, cap_key(1030), '0, r);
        check("cap_reins_val", r.found_value, cap_val(1030));

        // Backpressure: result held while ready is low
        issue(OP_SEARCH, cap_key(7), '0);
        wait_res(r);
        check("bp_rc", r.rescode, SEARCH_FOUND);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", res_if.valid, 1'b1);
            check("bp_cmd_ready", cmd_if.ready, 1'b0);
            check("bp_value", res_if.result.found_value, cap_val(7));
        end
        retire();

        // Reset in the middle of a chain walk
        issue(OP_SEARCH, cap_key(7), '0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_res_valid", res_if.valid, 1'b0);
        check("midrst_cmd_ready", cmd_if.ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_sweep_ready", cmd_if.ready, 1'b0);
        send(OP_SEARCH, cap_key(7), '0, r);
        check("midrst_key_gone", r.rescode, SEARCH_NOT_SUCCESS_NO_ENTRY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
